gp_key_schedule: RTL and testbench
==================================

Name: gp_key_schedule

Overview:
- Round-key expansion stage that sits directly upstream of the grasspopper block.
- Accepts a 256-bit master key and produces the ten 128-bit Kuznyechik round keys K1..K10 defined in GOST R 34.12-2015.
- Derives K3..K10 using 32 Feistel iterations of F[C_i].
- Holds all round keys in an internal register file that the encoder reads by index.
- Iterative datapath: one S layer per cycle, one R step per cycle.

Parameters:
- BLK_W, 128, block / round-key width. Fixed by the standard; overriding it is illegal.
- KEY_W, 256, master key width. Fixed.
- NUM_RK, 10, number of round keys. Fixed.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset. Asserting it (low) clears all state immediately.
- key_i  in  256  master key. key_i[255:128] is K1; key_i[127:0] is K2. Sampled only on the accepted start edge.
- start  in  1  one-cycle request to expand key_i. Ignored while busy=1.
- busy  out  1  expansion in progress.
- keys_valid  out  1  all of K1..K10 are valid for the current key.
- rk_addr  in  4  round-key read index; 0 selects K1, 9 selects K10.
- rk_o  out  128  combinational read of rk[rk_addr]. Returns 0 when rk_addr>9.

Behaviour:
- Reset values (reset=0):
  - FSM=IDLE; busy=0; keys_valid=0.
  - All rk registers = 0; iteration counter = 0; R counter = 0.
  - Working registers a1, a0, t = 0.
- States: IDLE, SX, LIN, STORE.
- IDLE, on start=1:
  - rk[0] <= key_i[255:128]; rk[1] <= key_i[127:0].
  - a1 <= key_i[255:128]; a0 <= key_i[127:0].
  - iter <= 0; keys_valid <= 0; busy <= 1; go to SX.
- SX (1 cycle):
  - t <= S(a1 ^ C[iter+1]); S applies pi byte-wise to all 16 bytes.
  - rcnt <= 0; go to LIN.
- LIN (16 cycles):
  - Each cycle t <= R(t); rcnt++.
  - R(a15..a0) = l(a15..a0) || a15..a1, where a15 is the MS byte.
  - l = XOR of GF(2^8) products, modulus 0x1C3, coefficients for a15..a0: 148,32,133,16,194,192,1,251,1,192,194,16,133,32,148,1.
  - On the cycle with rcnt==15: a1 <= R(t) ^ a0; a0 <= a1; iter++.
  - Next state: if iter[2:0] became 0, go to STORE; otherwise go to SX.
- STORE (1 cycle):
  - rk[2g+2] <= a1; rk[2g+3] <= a0, where g = (iter/8)-1.
  - If iter==32: busy <= 0, keys_valid <= 1, go to IDLE. Otherwise go to SX.
- Latency:
  - 17 cycles per Feistel iteration.
  - 137 cycles per round-key pair (8 iterations + 1 STORE).
  - busy falls and keys_valid rises exactly 548 clocks after the edge that sampled start.
- rk_o is purely combinational.
  - K1/K2 are readable from the cycle after start.
  - K3..K10 are readable only after their STORE.
  - The encoder may rely only on keys_valid=1.
- Boundary conditions:
  - start while busy: ignored, with no effect on state or on the key in flight.
  - start in the same cycle that keys_valid rises: sampled next cycle, since the FSM is in IDLE only afterwards.
  - Reset asserted mid-expansion: everything clears to reset values; keys_valid=0; no partial keys are retained.
  - A new start clears keys_valid before new keys are written. Old K3..K10 remain in rk until overwritten, but are flagged invalid.

Decomposition:
- Package gp_pkg, to be shared with grasspopper:
  - PI[0:255] S-box table.
  - Function gf_mul8 (poly 0x1C3).
  - L coefficient array.
  - Constants C[1:32] = L(Vec128(i)) as 128-bit literals.
  - FSM state enum.
- One sub-module, gp_r_step: a purely combinational 128-bit R transform, reused by the encoder's L layer.

Test Plan:
- Reset, then read every rk_addr 0..9 -> rk_o=0; busy=0; keys_valid=0.
- Standalone gp_r_step: input 00000000000000000000000000000100 -> output 94000000000000000000000000000001.
- Full key expansion, key 8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef, start pulse:
  - keys_valid at exactly +548 cycles.
  - K1=8899aabbccddeeff0011223344556677, K2=fedcba98765432100123456789abcdef.
  - K3=db31485315694343228d6aef8cc78c44, K4=3d4553d8e9cfec6815ebadc40a9ffd04.
  - K10=72e9dd7416bcf45b755dbaa88e4a4043.
- Pulse start again at +100 cycles with key_i=0 -> ignored; final keys identical to the previous scenario.
- Assert reset at +300 cycles -> busy=0, keys_valid=0, all rk=0 asynchronously. Re-run with start -> correct K1..K10 at +548.
- rk_addr=10..15 -> rk_o=0. Back-to-back start the cycle after keys_valid rises -> keys_valid drops next cycle and busy rises.

Source files
------------

// File: rtl/gp_pkg.sv
// Shared Kuznyechik constants and helpers: S-box, GF(2^8) multiply, linear-layer
// coefficients, round constants C1..C32 and the key-schedule FSM state type.
package gp_pkg;

   localparam int unsigned BLK_W  = 128;
   localparam int unsigned KEY_W  = 256;
   localparam int unsigned NUM_RK = 10;

   typedef logic [BLK_W-1:0] blk_t;

   typedef enum logic [1:0] {StIdle, StSx, StLin, StStore} ks_state_e;

   localparam logic [7:0] PI [256] = '{
      8'd252, 8'd238, 8'd221, 8'd17,  8'd207, 8'd110, 8'd49,  8'd22,
      8'd251, 8'd196, 8'd250, 8'd218, 8'd35,  8'd197, 8'd4,   8'd77,
      8'd233, 8'd119, 8'd240, 8'd219, 8'd147, 8'd46,  8'd153, 8'd186,
      8'd23,  8'd54,  8'd241, 8'd187, 8'd20,  8'd205, 8'd95,  8'd193,
      8'd249, 8'd24,  8'd101, 8'd90,  8'd226, 8'd92,  8'd239, 8'd33,
      8'd129, 8'd28,  8'd60,  8'd66,  8'd139, 8'd1,   8'd142, 8'd79,
      8'd5,   8'd132, 8'd2,   8'd174, 8'd227, 8'd106, 8'd143, 8'd160,
      8'd6,   8'd11,  8'd237, 8'd152, 8'd127, 8'd212, 8'd211, 8'd31,
      8'd235, 8'd52,  8'd44,  8'd81,  8'd234, 8'd200, 8'd72,  8'd171,
      8'd242, 8'd42,  8'd104, 8'd162, 8'd253, 8'd58,  8'd206, 8'd204,
      8'd181, 8'd112, 8'd14,  8'd86,  8'd8,   8'd12,  8'd118, 8'd18,
      8'd191, 8'd114, 8'd19,  8'd71,  8'd156, 8'd183, 8'd93,  8'd135,
      8'd21,  8'd161, 8'd150, 8'd41,  8'd16,  8'd123, 8'd154, 8'd199,
      8'd243, 8'd145, 8'd120, 8'd111, 8'd157, 8'd158, 8'd178, 8'd177,
      8'd50,  8'd117, 8'd25,  8'd61,  8'd255, 8'd53,  8'd138, 8'd126,
      8'd109, 8'd84,  8'd198, 8'd128, 8'd195, 8'd189, 8'd13,  8'd87,
      8'd223, 8'd245, 8'd36,  8'd169, 8'd62,  8'd168, 8'd67,  8'd201,
      8'd215, 8'd121, 8'd214, 8'd246, 8'd124, 8'd34,  8'd185, 8'd3,
      8'd224, 8'd15,  8'd236, 8'd222, 8'd122, 8'd148, 8'd176, 8'd188,
      8'd220, 8'd232, 8'd40,  8'd80,  8'd78,  8'd51,  8'd10,  8'd74,
      8'd167, 8'd151, 8'd96,  8'd115, 8'd30,  8'd0,   8'd98,  8'd68,
      8'd26,  8'd184, 8'd56,  8'd130, 8'd100, 8'd159, 8'd38,  8'd65,
      8'd173, 8'd69,  8'd70,  8'd146, 8'd39,  8'd94,  8'd85,  8'd47,
      8'd140, 8'd163, 8'd165, 8'd125, 8'd105, 8'd213, 8'd149, 8'd59,
      8'd7,   8'd88,  8'd179, 8'd64,  8'd134, 8'd172, 8'd29,  8'd247,
      8'd48,  8'd55,  8'd107, 8'd228, 8'd136, 8'd217, 8'd231, 8'd137,
      8'd225, 8'd27,  8'd131, 8'd73,  8'd76,  8'd63,  8'd248, 8'd254,
      8'd141, 8'd83,  8'd170, 8'd144, 8'd202, 8'd216, 8'd133, 8'd97,
      8'd32,  8'd113, 8'd103, 8'd164, 8'd45,  8'd43,  8'd9,   8'd91,
      8'd203, 8'd155, 8'd37,  8'd208, 8'd190, 8'd229, 8'd108, 8'd82,
      8'd89,  8'd166, 8'd116, 8'd210, 8'd230, 8'd244, 8'd180, 8'd192,
      8'd209, 8'd102, 8'd175, 8'd194, 8'd57,  8'd75,  8'd99,  8'd182
   };

   // Element [i] multiplies byte a_i; written MS byte (a15) first.
   localparam logic [15:0][7:0] L_COEF = {
      8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
      8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
   };

   function automatic logic [7:0] gf_mul8(logic [7:0] a, logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'hc3) : {x[6:0], 1'b0};
      end
      return p;
   endfunction

   function automatic blk_t r_func(blk_t a);
      logic [7:0] l;
      l = '0;
      for (int i = 0; i < 16; i++) l = l ^ gf_mul8(a[8*i +: 8], L_COEF[i]);
      return {l, a[BLK_W-1:8]};
   endfunction

   function automatic blk_t c_const(int unsigned i);
      blk_t v;
      v = blk_t'(i);
      for (int k = 0; k < 16; k++) v = r_func(v);
      return v;
   endfunction

   // C_TAB[i] holds C_(i+1); folded to literals at elaboration.
   localparam blk_t C_TAB [32] = '{
      c_const(1),  c_const(2),  c_const(3),  c_const(4),
      c_const(5),  c_const(6),  c_const(7),  c_const(8),
      c_const(9),  c_const(10), c_const(11), c_const(12),
      c_const(13), c_const(14), c_const(15), c_const(16),
      c_const(17), c_const(18), c_const(19), c_const(20),
      c_const(21), c_const(22), c_const(23), c_const(24),
      c_const(25), c_const(26), c_const(27), c_const(28),
      c_const(29), c_const(30), c_const(31), c_const(32)
   };

endpackage

// File: rtl/gp_key_schedule_if.sv
// Request/read-back bundle between the key-schedule block and its user.
interface gp_key_schedule_if;
   import gp_pkg::*;

   logic [KEY_W-1:0] key_i;
   logic             start;
   logic             busy;
   logic             keys_valid;
   logic [3:0]       rk_addr;
   blk_t             rk_o;

   modport master (
      output key_i, start, rk_addr,
      input  busy, keys_valid, rk_o
   );

   modport slave (
      input  key_i, start, rk_addr,
      output busy, keys_valid, rk_o
   );

endinterface

// File: rtl/gp_r_step.sv
// One combinational Kuznyechik R step: shift right by a byte, LFSR feedback byte on top.
module gp_r_step
   import gp_pkg::*;
(
   input  blk_t block,
   output blk_t rotated
);

   assign rotated = r_func(block);

endmodule

// File: rtl/gp_key_schedule.sv
// Iterative Kuznyechik key expansion: one S layer and sixteen R steps per Feistel round,
// round keys held in a register file read combinationally by index.
module gp_key_schedule
   import gp_pkg::*;
(
   input logic              clk,
   input logic              reset,
   gp_key_schedule_if.slave bus
);

   ks_state_e  state_q;
   logic       busy_q;
   logic       valid_q;
   logic [5:0] iter_q;
   logic [3:0] rcnt_q;
   blk_t       a1_q;
   blk_t       a0_q;
   blk_t       t_q;
   blk_t       rk_q [NUM_RK];

   blk_t       sx_in;
   blk_t       s_out;
   blk_t       r_out;
   logic [5:0] iter_next;
   logic [3:0] st_idx;

   always_comb begin
      sx_in = a1_q ^ C_TAB[iter_q[4:0]];
      s_out = '0;
      for (int i = 0; i < 16; i++) s_out[8*i +: 8] = PI[sx_in[8*i +: 8]];
   end

   gp_r_step u_r_step (
      .block   (t_q),
      .rotated (r_out)
   );

   assign iter_next = iter_q + 6'd1;
   // iter/4 is the even slot 2g+2 of the pair just finished.
   assign st_idx    = iter_q[5:2];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         iter_q  <= '0;
         rcnt_q  <= '0;
         a1_q    <= '0;
         a0_q    <= '0;
         t_q     <= '0;
         for (int i = 0; i < NUM_RK; i++) rk_q[i] <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  rk_q[0] <= bus.key_i[KEY_W-1:BLK_W];
                  rk_q[1] <= bus.key_i[BLK_W-1:0];
                  a1_q    <= bus.key_i[KEY_W-1:BLK_W];
                  a0_q    <= bus.key_i[BLK_W-1:0];
                  iter_q  <= '0;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= StSx;
               end
            end
            StSx: begin
               t_q     <= s_out;
               rcnt_q  <= '0;
               state_q <= StLin;
            end
            StLin: begin
               t_q    <= r_out;
               rcnt_q <= rcnt_q + 4'd1;
               if (rcnt_q == 4'd15) begin
                  a1_q    <= r_out ^ a0_q;
                  a0_q    <= a1_q;
                  iter_q  <= iter_next;
                  state_q <= (iter_next[2:0] == 3'd0) ? StStore : StSx;
               end
            end
            StStore: begin
               rk_q[st_idx]        <= a1_q;
               rk_q[st_idx + 4'd1] <= a0_q;
               if (iter_q == 6'd32) begin
                  busy_q  <= 1'b0;
                  valid_q <= 1'b1;
                  state_q <= StIdle;
               end else begin
                  state_q <= StSx;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.busy       = busy_q;
   assign bus.keys_valid = valid_q;

   always_comb begin
      bus.rk_o = '0;
      if (bus.rk_addr < 4'(NUM_RK)) bus.rk_o = rk_q[bus.rk_addr];
   end

endmodule

// File: tb/tb_gp_key_schedule.sv
// Directed bench for gp_key_schedule using the GOST R 34.12-2015 reference key.
module tb_gp_key_schedule;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   int   lat;
   logic [127:0] v;
   logic [127:0] r_in;
   logic [127:0] r_out;

   localparam logic [255:0] KEY =
      256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
   localparam logic [127:0] K1  = 128'h8899aabbccddeeff0011223344556677;
   localparam logic [127:0] K2  = 128'hfedcba98765432100123456789abcdef;
   localparam logic [127:0] K3  = 128'hdb31485315694343228d6aef8cc78c44;
   localparam logic [127:0] K4  = 128'h3d4553d8e9cfec6815ebadc40a9ffd04;
   localparam logic [127:0] K10 = 128'h72e9dd7416bcf45b755dbaa88e4a4043;

   gp_key_schedule_if bus_if ();

   gp_key_schedule dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   gp_r_step u_r (
      .block   (r_in),
      .rotated (r_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic read_rk(input int a, output logic [127:0] val);
      bus_if.rk_addr = 4'(a);
      #1;
      val = bus_if.rk_o;
   endtask

   // Starts an expansion and counts edges until keys_valid; optional ignored restart.
   task automatic expand(input logic [255:0] key, input int inject_at, output int n);
      logic [127:0] k;
      bus_if.key_i = key;
      bus_if.start = 1'b1;
      tick();
      bus_if.start = 1'b0;
      check("busy_after_start", 128'(bus_if.busy), 128'd1);
      check("valid_after_start", 128'(bus_if.keys_valid), 128'd0);
      read_rk(0, k);
      check("k1_early", k, key[255:128]);
      n = 0;
      while (bus_if.keys_valid !== 1'b1 && n < 700) begin
         tick();
         n++;
         if (n == inject_at) begin
            bus_if.key_i = '0;
            bus_if.start = 1'b1;
         end else begin
            bus_if.start = 1'b0;
         end
      end
      bus_if.start = 1'b0;
   endtask

   task automatic check_keys(input string tag);
      logic [127:0] k;
      read_rk(0, k); check({tag, "_k1"}, k, K1);
      read_rk(1, k); check({tag, "_k2"}, k, K2);
      read_rk(2, k); check({tag, "_k3"}, k, K3);
      read_rk(3, k); check({tag, "_k4"}, k, K4);
      read_rk(9, k); check({tag, "_k10"}, k, K10);
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      reset        = 1'b0;
      bus_if.start = 1'b0;
      bus_if.key_i = '0;
      bus_if.rk_addr = '0;
      r_in = '0;
      #2;
      for (int a = 0; a < 10; a++) begin
         read_rk(a, v);
         check($sformatf("reset_rk%0d", a), v, 128'd0);
      end
      check("reset_busy", 128'(bus_if.busy), 128'd0);
      check("reset_valid", 128'(bus_if.keys_valid), 128'd0);

      r_in = 128'h00000000000000000000000000000100;
      #1;
      check("r_step", r_out, 128'h94000000000000000000000000000001);

      @(negedge clk);
      reset = 1'b1;
      tick();

      // Clean expansion.
      expand(KEY, 0, lat);
      check("latency_a", 128'(lat), 128'd548);
      check_keys("run_a");
      tick();

      // Restart attempt while busy must not disturb the key in flight.
      expand(KEY, 100, lat);
      check("latency_b", 128'(lat), 128'd548);
      check_keys("run_b");
      tick();

      // Asynchronous reset mid-expansion.
      bus_if.key_i = KEY;
      bus_if.start = 1'b1;
      tick();
      bus_if.start = 1'b0;
      repeat (299) tick();
      #2;
      reset = 1'b0;
      #1;
      check("midreset_busy", 128'(bus_if.busy), 128'd0);
      check("midreset_valid", 128'(bus_if.keys_valid), 128'd0);
      for (int a = 0; a < 10; a++) begin
         read_rk(a, v);
         check($sformatf("midreset_rk%0d", a), v, 128'd0);
      end
      @(negedge clk);
      reset = 1'b1;
      tick();

      expand(KEY, 0, lat);
      check("latency_c", 128'(lat), 128'd548);

      // Back-to-back start on the first IDLE cycle, new key all zero.
      bus_if.key_i = '0;
      bus_if.start = 1'b1;
      tick();
      bus_if.start = 1'b0;
      check("b2b_valid", 128'(bus_if.keys_valid), 128'd0);
      check("b2b_busy", 128'(bus_if.busy), 128'd1);
      read_rk(0, v); check("b2b_k1_new", v, 128'd0);
      read_rk(1, v); check("b2b_k2_new", v, 128'd0);
      read_rk(2, v); check("b2b_k3_old", v, K3);
      read_rk(3, v); check("b2b_k4_old", v, K4);
      read_rk(9, v); check("b2b_k10_old", v, K10);
      for (int a = 10; a < 16; a++) begin
         read_rk(a, v);
         check($sformatf("oob_rk%0d", a), v, 128'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
